alu_regfile_mc: RTL
===================

Name: alu_regfile_mc

Overview:
Parametrised multi-cycle ALU with an integrated register file. It is the successor to the 2-bit FETCH/EXECUTE/WRITEBACK ALU.
- Operands come from the register file; results write back to it.
- Operation issue uses a start/busy/done handshake.
- Multiply and divide run iteratively: shift-add and restoring division, one bit per cycle.
- Intended as the datapath core beneath the team's simple sequencer/controller blocks.

Parameters:
- WIDTH, 8, datapath and register width in bits (>=2).
- NREGS, 4, number of registers (power of two, >=2). AW = clog2(NREGS).

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, request an operation; accepted only in IDLE.
- op, input, 3, operation select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 DIV, 111 LDI.
- rs_a, input, AW, source register A.
- rs_b, input, AW, source register B.
- rd, input, AW, destination register.
- wr_en, input, 1, write result to rd at write-back.
- imm, input, WIDTH, immediate value for LDI.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse in the WB state.
- result, output, WIDTH, registered ALU result; holds its value until the next write-back.
- carry, output, 1, carry / borrow / multiply overflow flag.
- zero, output, 1, result == 0.
- err, output, 1, divide-by-zero flag.
- dbg_addr, input, AW, debug read address.
- dbg_data, output, WIDTH, combinational read of regfile[dbg_addr].

Behaviour:
- Reset (asynchronous): state=IDLE. busy, done, result, carry, zero, err = 0. All registers = 0. Iteration counter = 0. Reset mid-operation aborts it, with no write-back.
- States:
  - IDLE: if start=1, capture op, rd, wr_en, imm, regfile[rs_a] and regfile[rs_b] on the edge. MUL goes to ITER. DIV with B!=0 goes to ITER. DIV with B==0 goes to WB. All other ops go to EXEC. start=0 stays in IDLE.
  - EXEC: one cycle computing ADD/SUB/logic/LDI into the internal result; then go to WB.
  - ITER: exactly WIDTH cycles, counter counting WIDTH-1 down to 0, one bit per cycle; then go to WB.
  - WB: one cycle. Drive done=1. Update result/carry/zero/err outputs. If wr_en=1 and err=0, regfile[rd] is written at the WB->IDLE edge. Then go to IDLE.
- Latency from the accept edge to the cycle where done=1:
  - EXEC ops: 2 cycles.
  - MUL and DIV(B!=0): WIDTH+1 cycles.
  - DIV(B==0): 1 cycle.
- Arithmetic, all unsigned, WIDTH bits:
  - ADD: {carry,result} = A+B.
  - SUB: result = A-B mod 2^WIDTH; carry=1 iff A<B (borrow).
  - AND/OR/XOR: bitwise; carry=0.
  - LDI: result = imm; carry=0.
  - MUL: result = low WIDTH bits of A*B; carry=1 iff the high WIDTH bits are nonzero.
  - DIV: result = quotient floor(A/B); remainder discarded; carry=0.
  - DIV with B==0: result = all ones, err=1, carry=0, regfile not written.
  - zero is computed from the final result in all cases. err=0 for all ops except DIV by zero.
- Handshake:
  - start is ignored while busy=1, including the WB cycle; no queueing.
  - A new start may be presented in the cycle after done and is accepted then.
  - Operands are captured at accept, so regfile changes during busy do not affect the operation in flight.
- Hazards: no back-to-back overlap is possible, so a dependent op issued after done reads the written-back value.
- rd==rs_a / rs_b is allowed.
- dbg_data reflects the write from the edge after WB.

Test Plan:
- Reset behaviour: reset asserted mid-ITER of a MUL -> busy=0, done=0, all registers 0, no write.
- Load and add (WIDTH=8): LDI r0=200, LDI r1=100, ADD r2=r0+r1 -> result=44, carry=1, zero=0, done exactly 2 cycles after accept, dbg r2=44.
- Subtract with borrow: SUB r3=r1-r0 -> result=156, carry=1. SUB r0-r0 -> result=0, zero=1, carry=0.
- Multiply: MUL 15*17 -> result=255, carry=0, done 9 cycles after accept. MUL 16*16 -> result=0, carry=1, zero=1.
- Divide: DIV 200/7 -> result=28, err=0, latency 9. DIV 5/0 -> result=255, err=1, done 1 cycle after accept, rd unchanged.
- Handshake: start held high continuously -> ops accepted only in IDLE, one per done, no accepts while busy=1. wr_en=0 -> outputs update but the register is unchanged.

Source files
------------

// File: rtl/alu_regfile_mc.sv
// Multi-cycle ALU with an integrated register file. Operations use a start/busy/done handshake.
// Multiply (shift-add) and divide (restoring) iterate one bit per cycle.
module alu_regfile_mc #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 4,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rs_a,
  input  logic [AW-1:0]    rs_b,
  input  logic [AW-1:0]    rd,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] imm,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             err,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpMul = 3'b101;
  localparam logic [2:0] OpDiv = 3'b110;
  localparam logic [2:0] OpLdi = 3'b111;

  typedef enum logic [1:0] {StIdle, StExec, StIter, StWb} state_e;

  state_e           state_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, zero_q, err_q;
  logic [2:0]       op_q;
  logic [AW-1:0]    rd_q;
  logic             wr_en_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] regs [NREGS];

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign err      = err_q;
  assign dbg_data = regs[dbg_addr];

  // Single-cycle operations
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] exec_res;
  logic             exec_carry;

  always_comb begin
    sum_ext    = {1'b0, a_q} + {1'b0, b_q};
    diff_ext   = {1'b0, a_q} - {1'b0, b_q};
    exec_res   = '0;
    exec_carry = 1'b0;
    case (op_q)
      OpAdd: begin
        exec_res   = sum_ext[WIDTH-1:0];
        exec_carry = sum_ext[WIDTH];
      end
      OpSub: begin
        exec_res   = diff_ext[WIDTH-1:0];
        exec_carry = diff_ext[WIDTH];
      end
      OpAnd:   exec_res = a_q & b_q;
      OpOr:    exec_res = a_q | b_q;
      OpXor:   exec_res = a_q ^ b_q;
      OpLdi:   exec_res = imm_q;
      default: exec_res = '0;
    endcase
  end

  // One iteration step. MUL: {hi,lo} is partial product with multiplier shifting out of lo.
  // DIV: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] iter_hi, iter_lo;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ok    = ~div_diff[WIDTH];
    if (op_q == OpMul) begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      iter_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      iter_lo = {lo_q[WIDTH-2:0], div_ok};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      op_q     <= OpAdd;
      rd_q     <= '0;
      wr_en_q  <= 1'b0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            op_q    <= op;
            rd_q    <= rd;
            wr_en_q <= wr_en;
            imm_q   <= imm;
            a_q     <= regs[rs_a];
            b_q     <= regs[rs_b];
            busy_q  <= 1'b1;
            if (op == OpMul) begin
              hi_q    <= '0;
              lo_q    <= regs[rs_b];
              cnt_q   <= CW'(WIDTH - 1);
              state_q <= StIter;
            end else if (op == OpDiv && regs[rs_b] == '0) begin
              // Divide by zero skips straight to write-back with the error set
              result_q <= '1;
              carry_q  <= 1'b0;
              zero_q   <= 1'b0;
              err_q    <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= StWb;
            end else if (op == OpDiv) begin
              hi_q    <= '0;
              lo_q    <= regs[rs_a];
              cnt_q   <= CW'(WIDTH - 1);
              state_q <= StIter;
            end else begin
              state_q <= StExec;
            end
          end
        end
        StExec: begin
          result_q <= exec_res;
          carry_q  <= exec_carry;
          zero_q   <= (exec_res == '0);
          err_q    <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= StWb;
        end
        StIter: begin
          hi_q <= iter_hi;
          lo_q <= iter_lo;
          if (cnt_q == '0) begin
            result_q <= iter_lo;
            carry_q  <= (op_q == OpMul) && (iter_hi != '0);
            zero_q   <= (iter_lo == '0);
            err_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StWb;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWb: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Write-back lands on the WB->IDLE edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (state_q == StWb && wr_en_q && !err_q) begin
      regs[rd_q] <= result_q;
    end
  end

endmodule
